btb_lookup: RTL
===============

BTB_LOOKUP -- requirements
Module: btb_lookup

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 if_pc  input  32  IF-stage fetch PC; tag = if_pc[31:5], index = if_pc[4:2].
REQ-005 if_stall  input  1  when high, hold registered lookup outputs and suppress the read-side LRU update.
REQ-006 predict_hit  output  1  registered flag: valid tag match for the PC sampled last edge.
REQ-007 predict_taken  output  1  registered flag: hit way state[1]==1.
REQ-008 predict_target  output  32  registered target of the hit way; 0 on miss.
REQ-009 update_index  input  3  EX-stage set index, supplied by the BTB update logic.
REQ-010 update_set  output  128  combinational read of array[update_index] for the update logic.
REQ-011 update_lru  output  8  combinational copy of the LRU register.
REQ-012 update_en  input  1  EX-stage write strobe.
REQ-013 write_set  input  128  new set contents written to array[update_index] when update_en is high.
REQ-014 next_lru_write  input  1  new LRU bit for set update_index when update_en is high.

Function
REQ-015 Storage SHALL be 8 sets x 128 bits: way1 = [127:64], way2 = [63:0].
REQ-016 Each way SHALL be laid out as valid [63], tag [62:36], target [35:4], state [3:2], pad [1:0] = 00.
REQ-017 LRU SHALL be 8 bits, one per set; LRU[i]=1 means way1 is the victim, and LRU[i]=0 means way2 is the victim.
REQ-018 A way SHALL match when its valid bit is 1 and its tag equals if_pc[31:5].
REQ-019 If both ways match, way1 SHALL take priority.
REQ-020 Lookup latency SHALL be 1 cycle: the outputs register the result for the if_pc sampled at the same edge.
REQ-021 On a miss, the outputs SHALL be predict_hit=0, predict_taken=0, predict_target=0.
REQ-022 predict_taken SHALL be 1 only for states 10 (weak taken) and 11 (strong taken).
REQ-023 On a non-stalled read hit, LRU[index] SHALL be set to 0 for a way1 hit and to 1 for a way2 hit.
REQ-024 On a miss, the read side SHALL leave LRU unchanged.
REQ-025 When update_en=1, the block SHALL write array[update_index] <= write_set and LRU[update_index] <= next_lru_write at the edge.
REQ-026 If an update write and a read-hit LRU update target the same set in the same cycle, the update write's LRU value SHALL win.
REQ-027 If they target different sets in the same cycle, both LRU updates SHALL apply.
REQ-028 A lookup to a set being written in the same cycle SHALL see the pre-write contents (read-before-write, no bypass).
REQ-029 The update write SHALL proceed regardless of if_stall.
REQ-030 update_set and update_lru SHALL reflect state before the current edge; they SHALL NOT be forwarded from write_set.
REQ-031 The block SHALL NOT update any 2-bit state; only the update path changes state.

Reset
REQ-032 While rst=1 at an edge, all 8 sets SHALL clear to 128'h0 and LRU SHALL clear to 8'h00.
REQ-033 While rst=1 at an edge, predict_hit, predict_taken and predict_target SHALL clear to 0.
REQ-034 Reset SHALL take priority over update_en and if_stall.
REQ-035 After reset, every lookup SHALL miss until a set is written.
REQ-036 Reset asserted mid-stall SHALL clear the held outputs.

Verification
REQ-037 Reset, then if_pc=32'h0000_0040 for 3 cycles -> predict_hit=0, predict_target=0, update_lru=8'h00.
REQ-038 Write set 2: way1 = {valid 1, tag 27'h0000002, target 32'h0000_0100, state 11}, update_en=1; next cycle if_pc=32'h0000_0048 -> one cycle later predict_hit=1, predict_taken=1, predict_target=32'h0000_0100, LRU[2]=0.
REQ-039 Same entry rewritten with state 01 -> lookup gives predict_hit=1, predict_taken=0, predict_target=32'h0000_0100.
REQ-040 Way2 of set 5 valid, LRU[5]=0; lookup that hits way2 -> LRU[5]=1. Same cycle as update_en to set 5 with next_lru_write=0 -> LRU[5]=0.
REQ-041 if_stall=1 while if_pc changes from a hit PC to a miss PC -> outputs hold the hit values and LRU does not change; if_stall=0 -> miss appears one cycle later.
REQ-042 Same-cycle write and lookup to set 3 changing the target 0x200 -> 0x300 -> that lookup returns 0x200; the following lookup returns 0x300.

Source files
------------

// File: rtl/btb_lookup.sv
// btb_lookup: 8-set 2-way BTB with a registered one-cycle lookup and an EX-side set read/write port
module btb_lookup (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  if_pc,
    input  logic         if_stall,
    output logic         predict_hit,
    output logic         predict_taken,
    output logic [31:0]  predict_target,
    input  logic [2:0]   update_index,
    output logic [127:0] update_set,
    output logic [7:0]   update_lru,
    input  logic         update_en,
    input  logic [127:0] write_set,
    input  logic         next_lru_write
);
    logic [127:0] array_q [8];
    logic [127:0] array_d [8];
    logic [7:0]   lru_q, lru_d;
    logic         hit_q, hit_d, taken_q, taken_d;
    logic [31:0]  target_q, target_d;
    logic [127:0] rd_set;
    logic [63:0]  rd_way;
    logic [2:0]   rd_idx;
    logic         m1, m2, hit;
    logic         unused_bits;

    assign rd_idx = if_pc[4:2];
    assign rd_set = array_q[rd_idx];
    assign m1 = rd_set[127] && rd_set[126:100] == if_pc[31:5];
    assign m2 = rd_set[63] && rd_set[62:36] == if_pc[31:5];
    assign hit = m1 || m2;
    assign rd_way = m1 ? rd_set[127:64] : rd_set[63:0];
    assign unused_bits = ^{if_pc[1:0], rd_way[63:36], rd_way[2:0]};

    // read-side LRU first so a same-set update write overrides it
    always_comb begin
        array_d = array_q;
        lru_d = lru_q;
        hit_d = hit_q;
        taken_d = taken_q;
        target_d = target_q;
        if (!if_stall) begin
            hit_d = hit;
            taken_d = hit && rd_way[3];
            target_d = hit ? rd_way[35:4] : '0;
            if (hit) lru_d[rd_idx] = !m1;
        end
        if (update_en) begin
            array_d[update_index] = write_set;
            lru_d[update_index] = next_lru_write;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            array_q <= '{default: '0};
            lru_q <= '0;
            hit_q <= 1'b0;
            taken_q <= 1'b0;
            target_q <= '0;
        end else begin
            array_q <= array_d;
            lru_q <= lru_d;
            hit_q <= hit_d;
            taken_q <= taken_d;
            target_q <= target_d;
        end
    end

    assign predict_hit = hit_q;
    assign predict_taken = taken_q;
    assign predict_target = target_q;
    assign update_set = array_q[update_index];
    assign update_lru = lru_q;
endmodule
